// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: writeback, load-issue and read-port bundle.
// master drives writes/sets/read addresses; slave is the register file.
interface regfile_scoreboard_if #(
    parameter int BITWIDTH        = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int READPORTS       = 2,
    parameter int COUNTWIDTH      = 5
);
    logic                                 Write_En;
    logic [REGADDRBITWIDTH-1:0]           Write_Addr;
    logic [BITWIDTH-1:0]                  Write_Data;
    logic                                 Dirty_Set;
    logic [REGADDRBITWIDTH-1:0]           Dirty_Addr;
    logic                                 Mem_Write_En;
    logic [REGADDRBITWIDTH-1:0]           Mem_Write_Addr;
    logic [BITWIDTH-1:0]                  Mem_Write_Data;
    logic [READPORTS*REGADDRBITWIDTH-1:0] Read_Addr;
    logic [READPORTS*BITWIDTH-1:0]        Read_Data;
    logic [READPORTS-1:0]                 Read_Dirty;
    logic [COUNTWIDTH-1:0]                Dirty_Count;
    logic                                 Dirty_Conflict;
    logic                                 Collision_Error;

    modport master (
        output Write_En, Write_Addr, Write_Data,
        output Dirty_Set, Dirty_Addr,
        output Mem_Write_En, Mem_Write_Addr, Mem_Write_Data,
        output Read_Addr,
        input  Read_Data, Read_Dirty, Dirty_Count,
        input  Dirty_Conflict, Collision_Error
    );

    modport slave (
        input  Write_En, Write_Addr, Write_Data,
        input  Dirty_Set, Dirty_Addr,
        input  Mem_Write_En, Mem_Write_Addr, Mem_Write_Data,
        input  Read_Addr,
        output Read_Data, Read_Dirty, Dirty_Count,
        output Dirty_Conflict, Collision_Error
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with per-register dirty scoreboard.
// Ports: clk, async_rst (async, active high), clk_en (global enable), bus (slave).
module regfile_scoreboard #(
    parameter int BITWIDTH        = 16,
    parameter int REGCOUNT        = 16,
    parameter int READPORTS       = 2,
    parameter int REGADDRBITWIDTH = $clog2(REGCOUNT),
    parameter int COUNTWIDTH      = $clog2(REGCOUNT) + 1
) (
    input logic                  clk,
    input logic                  async_rst,
    input logic                  clk_en,
    regfile_scoreboard_if.slave  bus
);
    logic [BITWIDTH-1:0]        regQ [REGCOUNT];
    logic [REGCOUNT-1:0]        dirtyQ;
    logic [COUNTWIDTH-1:0]      countQ;
    logic                       collisionQ;

    logic                       sameSetMem;
    logic                       setEff;
    logic                       clrEff;
    logic                       collide;

    logic [READPORTS*BITWIDTH-1:0] rdData;
    logic [READPORTS-1:0]          rdDirty;
    logic [REGADDRBITWIDTH-1:0]    ra;

    always_comb begin
        sameSetMem = bus.Dirty_Addr == bus.Mem_Write_Addr;
        setEff = bus.Dirty_Set && (bus.Dirty_Addr != '0)
                 && !dirtyQ[bus.Dirty_Addr];
        // A load return to a register that is re-issued in the same
        // cycle leaves it dirty, so it must not decrement the count.
        clrEff = bus.Mem_Write_En && (bus.Mem_Write_Addr != '0)
                 && dirtyQ[bus.Mem_Write_Addr]
                 && !(bus.Dirty_Set && sameSetMem);
        collide = bus.Write_En && bus.Mem_Write_En
                  && (bus.Write_Addr == bus.Mem_Write_Addr)
                  && (bus.Write_Addr != '0);
    end

    assign bus.Dirty_Conflict = clk_en && bus.Dirty_Set
                                && (bus.Dirty_Addr != '0)
                                && dirtyQ[bus.Dirty_Addr]
                                && !(bus.Mem_Write_En && sameSetMem);

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < REGCOUNT; i++) begin
                regQ[i] <= '0;
            end
            dirtyQ     <= '0;
            countQ     <= '0;
            collisionQ <= 1'b0;
        end else if (clk_en) begin
            // Entry 0 is never written; it stays at its reset value.
            for (int i = 1; i < REGCOUNT; i++) begin
                if (bus.Mem_Write_En
                    && bus.Mem_Write_Addr == REGADDRBITWIDTH'(i)) begin
                    regQ[i] <= bus.Mem_Write_Data;
                end else if (bus.Write_En
                    && bus.Write_Addr == REGADDRBITWIDTH'(i)) begin
                    regQ[i] <= bus.Write_Data;
                end
                if (bus.Dirty_Set
                    && bus.Dirty_Addr == REGADDRBITWIDTH'(i)) begin
                    dirtyQ[i] <= 1'b1;
                end else if (bus.Mem_Write_En
                    && bus.Mem_Write_Addr == REGADDRBITWIDTH'(i)) begin
                    dirtyQ[i] <= 1'b0;
                end
            end
            countQ <= countQ + COUNTWIDTH'(setEff)
                      - COUNTWIDTH'(clrEff);
            if (collide) begin
                collisionQ <= 1'b1;
            end
        end
    end

    // Read ports: load return bypass outranks ALU bypass, matching
    // the memory-wins write arbitration.
    always_comb begin
        rdData  = '0;
        rdDirty = '0;
        ra      = '0;
        for (int p = 0; p < READPORTS; p++) begin
            ra = bus.Read_Addr[p*REGADDRBITWIDTH +: REGADDRBITWIDTH];
            if (ra == '0) begin
                rdData[p*BITWIDTH +: BITWIDTH] = '0;
                rdDirty[p] = 1'b0;
            end else if (clk_en && bus.Mem_Write_En
                         && bus.Mem_Write_Addr == ra) begin
                rdData[p*BITWIDTH +: BITWIDTH] = bus.Mem_Write_Data;
                rdDirty[p] = 1'b0;
            end else if (clk_en && bus.Write_En
                         && bus.Write_Addr == ra) begin
                rdData[p*BITWIDTH +: BITWIDTH] = bus.Write_Data;
                rdDirty[p] = dirtyQ[ra];
            end else begin
                rdData[p*BITWIDTH +: BITWIDTH] = regQ[ra];
                rdDirty[p] = dirtyQ[ra];
            end
        end
    end

    assign bus.Read_Data       = rdData;
    assign bus.Read_Dirty      = rdDirty;
    assign bus.Dirty_Count     = countQ;
    assign bus.Collision_Error = collisionQ;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors for regfile_scoreboard.
// Drives the bus interface and checks read, scoreboard and error outputs.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic async_rst;
    logic clk_en;
    int   vectors = 0;
    int   miscompares = 0;

    regfile_scoreboard_if #(
        .BITWIDTH(16), .REGADDRBITWIDTH(4),
        .READPORTS(2), .COUNTWIDTH(5)
    ) bus ();

    regfile_scoreboard dut (
        .clk(clk),
        .async_rst(async_rst),
        .clk_en(clk_en),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input int p);
        return bus.Read_Data[p*16 +: 16];
    endfunction

    task automatic idle();
        bus.Write_En       = 1'b0;
        bus.Write_Addr     = '0;
        bus.Write_Data     = '0;
        bus.Dirty_Set      = 1'b0;
        bus.Dirty_Addr     = '0;
        bus.Mem_Write_En   = 1'b0;
        bus.Mem_Write_Addr = '0;
        bus.Mem_Write_Data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setRead(input logic [3:0] a0, input logic [3:0] a1);
        bus.Read_Addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        async_rst = 1'b1;
        clk_en = 1'b1;
        idle();
        bus.Read_Addr = '0;
        #2;
        for (int i = 0; i < 16; i++) begin
            setRead(4'(i), 4'(15 - i));
            vectors++;
            if (rd(0) !== 16'h0 || rd(1) !== 16'h0
                || bus.Read_Dirty !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_read r%0d: data %h/%h dirty %b, need 0/0 00",
                         i, rd(0), rd(1), bus.Read_Dirty);
            end
        end
        vectors++;
        if (bus.Dirty_Count !== 5'd0 || bus.Collision_Error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: count %0d coll %b, need 0 0",
                     bus.Dirty_Count, bus.Collision_Error);
        end
        async_rst = 1'b0;
        step();
        bus.Write_En = 1'b1;
        bus.Write_Addr = 4'd0;
        bus.Write_Data = 16'hBEEF;
        setRead(4'd0, 4'd0);
        vectors++;
        if (rd(0) !== 16'h0) begin
            miscompares++;
            $display("FAIL r0_bypass: got %h need 0000", rd(0));
        end
        step();
        idle();
        #1;
        vectors++;
        if (rd(0) !== 16'h0 || bus.Read_Dirty[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_write: got %h dirty %b need 0000 0",
                     rd(0), bus.Read_Dirty[0]);
        end
    endtask

    task automatic test_load_return();
        bus.Dirty_Set = 1'b1;
        bus.Dirty_Addr = 4'd5;
        setRead(4'd5, 4'd0);
        vectors++;
        if (bus.Read_Dirty[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL set_same_cycle: dirty %b need 0", bus.Read_Dirty[0]);
        end
        step();
        idle();
        #1;
        vectors++;
        if (bus.Read_Dirty[0] !== 1'b1 || bus.Dirty_Count !== 5'd1) begin
            miscompares++;
            $display("FAIL set_r5: dirty %b count %0d need 1 1",
                     bus.Read_Dirty[0], bus.Dirty_Count);
        end
        bus.Mem_Write_En = 1'b1;
        bus.Mem_Write_Addr = 4'd5;
        bus.Mem_Write_Data = 16'h1234;
        #1;
        vectors++;
        if (rd(0) !== 16'h1234 || bus.Read_Dirty[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_bypass: got %h dirty %b need 1234 0",
                     rd(0), bus.Read_Dirty[0]);
        end
        step();
        idle();
        #1;
        vectors++;
        if (rd(0) !== 16'h1234 || bus.Read_Dirty[0] !== 1'b0
            || bus.Dirty_Count !== 5'd0) begin
            miscompares++;
            $display("FAIL mem_store: got %h dirty %b count %0d need 1234 0 0",
                     rd(0), bus.Read_Dirty[0], bus.Dirty_Count);
        end
    endtask

    task automatic test_set_and_return();
        bus.Dirty_Set = 1'b1;
        bus.Dirty_Addr = 4'd3;
        step();
        bus.Mem_Write_En = 1'b1;
        bus.Mem_Write_Addr = 4'd3;
        bus.Mem_Write_Data = 16'h00AA;
        setRead(4'd3, 4'd3);
        vectors++;
        if (bus.Dirty_Conflict !== 1'b0 || bus.Dirty_Count !== 5'd1) begin
            miscompares++;
            $display("FAIL set_ret_conflict: conf %b count %0d need 0 1",
                     bus.Dirty_Conflict, bus.Dirty_Count);
        end
        step();
        idle();
        #1;
        vectors++;
        if (rd(0) !== 16'h00AA || bus.Read_Dirty[0] !== 1'b1
            || bus.Dirty_Count !== 5'd1) begin
            miscompares++;
            $display("FAIL set_ret_store: got %h dirty %b count %0d need 00aa 1 1",
                     rd(0), bus.Read_Dirty[0], bus.Dirty_Count);
        end
        bus.Mem_Write_En = 1'b1;
        bus.Mem_Write_Addr = 4'd3;
        bus.Mem_Write_Data = 16'h00AA;
        step();
        idle();
        #1;
        vectors++;
        if (bus.Dirty_Count !== 5'd0 || bus.Read_Dirty[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL r3_clear: count %0d dirty %b need 0 0",
                     bus.Dirty_Count, bus.Read_Dirty[0]);
        end
    endtask

    task automatic test_collision();
        bus.Write_En = 1'b1;
        bus.Write_Addr = 4'd7;
        bus.Write_Data = 16'h1111;
        bus.Mem_Write_En = 1'b1;
        bus.Mem_Write_Addr = 4'd7;
        bus.Mem_Write_Data = 16'h2222;
        setRead(4'd7, 4'd7);
        vectors++;
        if (rd(1) !== 16'h2222 || bus.Collision_Error !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_bypass: got %h coll %b need 2222 0",
                     rd(1), bus.Collision_Error);
        end
        step();
        idle();
        #1;
        vectors++;
        if (rd(0) !== 16'h2222 || bus.Collision_Error !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_store: got %h coll %b need 2222 1",
                     rd(0), bus.Collision_Error);
        end
        repeat (3) step();
        vectors++;
        if (bus.Collision_Error !== 1'b1 || bus.Dirty_Count !== 5'd0) begin
            miscompares++;
            $display("FAIL coll_sticky: coll %b count %0d need 1 0",
                     bus.Collision_Error, bus.Dirty_Count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i < 16; i++) begin
            bus.Dirty_Set = 1'b1;
            bus.Dirty_Addr = 4'(i);
            #1;
            vectors++;
            if (bus.Dirty_Conflict !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_conflict r%0d: got %b need 0",
                         i, bus.Dirty_Conflict);
            end
            step();
        end
        idle();
        setRead(4'd15, 4'd1);
        vectors++;
        if (bus.Dirty_Count !== 5'd15 || bus.Read_Dirty !== 2'b11) begin
            miscompares++;
            $display("FAIL fill_count: count %0d dirty %b need 15 11",
                     bus.Dirty_Count, bus.Read_Dirty);
        end
        bus.Dirty_Set = 1'b1;
        bus.Dirty_Addr = 4'd2;
        #1;
        vectors++;
        if (bus.Dirty_Conflict !== 1'b1) begin
            miscompares++;
            $display("FAIL repeat_conflict: got %b need 1", bus.Dirty_Conflict);
        end
        step();
        bus.Dirty_Addr = 4'd0;
        #1;
        vectors++;
        if (bus.Dirty_Conflict !== 1'b0 || bus.Dirty_Count !== 5'd15) begin
            miscompares++;
            $display("FAIL repeat_count: conf %b count %0d need 0 15",
                     bus.Dirty_Conflict, bus.Dirty_Count);
        end
        step();
        idle();
        #1;
        vectors++;
        if (bus.Dirty_Count !== 5'd15) begin
            miscompares++;
            $display("FAIL r0_set_count: got %0d need 15", bus.Dirty_Count);
        end
    endtask

    task automatic test_clk_en();
        clk_en = 1'b0;
        bus.Write_En = 1'b1;
        bus.Write_Addr = 4'd1;
        bus.Write_Data = 16'h5555;
        bus.Mem_Write_En = 1'b1;
        bus.Mem_Write_Addr = 4'd2;
        bus.Mem_Write_Data = 16'h6666;
        bus.Dirty_Set = 1'b1;
        bus.Dirty_Addr = 4'd4;
        setRead(4'd1, 4'd2);
        vectors++;
        if (rd(0) !== 16'h0 || rd(1) !== 16'h0 || bus.Read_Dirty !== 2'b11
            || bus.Dirty_Conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL gated_bypass: %h %h dirty %b conf %b need 0 0 11 0",
                     rd(0), rd(1), bus.Read_Dirty, bus.Dirty_Conflict);
        end
        step();
        vectors++;
        if (rd(0) !== 16'h0 || rd(1) !== 16'h0 || bus.Read_Dirty !== 2'b11
            || bus.Dirty_Count !== 5'd15) begin
            miscompares++;
            $display("FAIL gated_hold: %h %h dirty %b count %0d need 0 0 11 15",
                     rd(0), rd(1), bus.Read_Dirty, bus.Dirty_Count);
        end
        clk_en = 1'b1;
        bus.Dirty_Set = 1'b0;
        #1;
        vectors++;
        if (rd(0) !== 16'h5555 || rd(1) !== 16'h6666
            || bus.Read_Dirty !== 2'b01) begin
            miscompares++;
            $display("FAIL dual_bypass: %h %h dirty %b need 5555 6666 01",
                     rd(0), rd(1), bus.Read_Dirty);
        end
        step();
        idle();
        #1;
        vectors++;
        if (rd(0) !== 16'h5555 || rd(1) !== 16'h6666
            || bus.Read_Dirty !== 2'b01 || bus.Dirty_Count !== 5'd14) begin
            miscompares++;
            $display("FAIL dual_store: %h %h dirty %b count %0d need 5555 6666 01 14",
                     rd(0), rd(1), bus.Read_Dirty, bus.Dirty_Count);
        end
    endtask

    task automatic test_async_reset();
        #3;
        async_rst = 1'b1;
        #1;
        setRead(4'd1, 4'd7);
        vectors++;
        if (bus.Dirty_Count !== 5'd0 || bus.Collision_Error !== 1'b0
            || rd(0) !== 16'h0 || rd(1) !== 16'h0
            || bus.Read_Dirty !== 2'b00) begin
            miscompares++;
            $display("FAIL async_clear: count %0d coll %b %h %h dirty %b",
                     bus.Dirty_Count, bus.Collision_Error,
                     rd(0), rd(1), bus.Read_Dirty);
        end
        bus.Dirty_Set = 1'b1;
        bus.Dirty_Addr = 4'd9;
        step();
        vectors++;
        if (bus.Dirty_Count !== 5'd0) begin
            miscompares++;
            $display("FAIL rst_hold: count %0d need 0", bus.Dirty_Count);
        end
        async_rst = 1'b0;
        step();
        idle();
        setRead(4'd9, 4'd0);
        vectors++;
        if (bus.Dirty_Count !== 5'd1 || bus.Read_Dirty !== 2'b01) begin
            miscompares++;
            $display("FAIL post_rst_set: count %0d dirty %b need 1 01",
                     bus.Dirty_Count, bus.Read_Dirty);
        end
    endtask

    initial begin
        test_reset();
        test_load_return();
        test_set_and_return();
        test_collision();
        test_fill();
        test_clk_en();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
